trim_rx: RTL and testbench

TRIM_RX -- requirements
Module: trim_rx

---
 rtl/trim_rx.sv | 120 ++++++++++++
 tb/tb_trim_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trim_rx.sv
// rtl/trim_rx.sv - serial trim-code receiver: synchronizes ENCLK/DIN, shifts LSB-first bits,
// and closes a frame after GAP_CYCLES of ENCLK silence.
module trim_rx #(
   parameter int FRAME_BITS = 12,
   parameter int GAP_CYCLES = 60000000,
   parameter int GAP_W      = 26
) (
   input  logic                  CLK50,
   input  logic                  RST,
   input  logic                  ENCLK,
   input  logic                  DIN,
   output logic [FRAME_BITS-1:0] CODE,
   output logic                  CODE_VALID,
   output logic                  FRAME_ERR,
   output logic [7:0]            FRAME_CNT,
   output logic                  BUSY
);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [4:0]       FULL_CNT = 5'(FRAME_BITS);

   state_t                  state, state_nxt;
   logic                    enclk_s1, enclk_s2, enclk_d;
   logic                    din_s1, din_s2;
   logic [FRAME_BITS-1:0]   shift;
   logic [4:0]              bit_cnt;
   logic [GAP_W-1:0]        gap_cnt;
   logic                    bit_ev;
   logic                    expire;

   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         enclk_s1 <= 1'b0;
         enclk_s2 <= 1'b0;
         enclk_d  <= 1'b0;
         din_s1   <= 1'b0;
         din_s2   <= 1'b0;
      end else begin
         enclk_s1 <= ENCLK;
         enclk_s2 <= enclk_s1;
         enclk_d  <= enclk_s2;
         din_s1   <= DIN;
         din_s2   <= din_s1;
      end
   end

   assign bit_ev = enclk_s2 & ~enclk_d;
   assign expire = (gap_cnt == GAP_LAST);

   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // A bit event always wins over gap expiry, including one landing in DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bit_ev) state_nxt = RECV;
         RECV:    if (!bit_ev && expire) state_nxt = DONE;
         DONE:    state_nxt = bit_ev ? RECV : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state == RECV);
   end

   // Frame results are registered on the RECV->DONE edge so the pulses sit in the DONE cycle.
   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         shift      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         CODE       <= '0;
         CODE_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
         FRAME_CNT  <= '0;
      end else begin
         CODE_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
         if (bit_ev) shift <= {din_s2, shift[FRAME_BITS-1:1]};
         case (state)
            IDLE: begin
               gap_cnt <= '0;
               if (bit_ev) bit_cnt <= 5'd1;
            end
            RECV: begin
               if (bit_ev) begin
                  gap_cnt <= '0;
                  if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
                  if (expire) begin
                     if (bit_cnt >= FULL_CNT) begin
                        CODE       <= shift;
                        CODE_VALID <= 1'b1;
                        FRAME_CNT  <= FRAME_CNT + 8'd1;
                     end else begin
                        FRAME_ERR  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               gap_cnt <= '0;
               bit_cnt <= bit_ev ? 5'd1 : 5'd0;
            end
            default: begin
               gap_cnt <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trim_rx.sv
// tb/tb_trim_rx.sv - directed bench for trim_rx with a frame-level reference model.
module tb_trim_rx;

   localparam int FB  = 12;
   localparam int GAP = 16;

   logic          clk50 = 1'b0;
   logic          rst   = 1'b1;
   logic          enclk = 1'b0;
   logic          din   = 1'b0;
   logic [FB-1:0] code;
   logic          code_valid;
   logic          frame_err;
   logic [7:0]    frame_cnt;
   logic          busy;

   int passed = 0;
   int total  = 0;
   int cv_tot = 0;
   int fe_tot = 0;

   logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
   logic d1 = 1'b0, d2 = 1'b0;

   trim_rx #(.FRAME_BITS(FB), .GAP_CYCLES(GAP), .GAP_W(5)) dut (
      .CLK50(clk50), .RST(rst), .ENCLK(enclk), .DIN(din),
      .CODE(code), .CODE_VALID(code_valid), .FRAME_ERR(frame_err),
      .FRAME_CNT(frame_cnt), .BUSY(busy)
   );

   always #10 clk50 = ~clk50;

   // Input history as seen through the two-stage synchronizer.
   always @(posedge clk50) begin
      if (rst) begin
         p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0; d1 <= 1'b0; d2 <= 1'b0;
      end else begin
         p1 <= enclk; p2 <= p1; p3 <= p2; d1 <= din; d2 <= d1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic compare_loop();
      int      cyc = 0, last_ev = 0, first_ev = 0, nbits = 0;
      bit      in_frame = 0;
      logic    q[$];
      logic    ev;
      logic [FB-1:0] e_code = '0;
      logic [7:0]    e_cnt  = '0;
      logic    e_cv, e_fe, e_busy;
      logic [FB+10:0] act, exp;
      forever begin
         @(negedge clk50);
         cyc++;
         e_cv = 1'b0; e_fe = 1'b0;
         if (rst) begin
            in_frame = 0; q.delete(); nbits = 0;
            e_code = '0; e_cnt = '0; e_busy = 1'b0;
         end else begin
            ev = p2 & ~p3;
            if (in_frame && cyc == last_ev + GAP + 1) begin
               if (nbits >= FB) begin
                  for (int j = 0; j < FB; j++) e_code[j] = q[q.size() - FB + j];
                  e_cv  = 1'b1;
                  e_cnt = e_cnt + 8'd1;
               end else begin
                  e_fe = 1'b1;
               end
               in_frame = 0;
            end
            if (ev) begin
               if (!in_frame) begin
                  in_frame = 1; nbits = 0; q.delete(); first_ev = cyc;
               end
               q.push_back(d2);
               if (q.size() > FB) void'(q.pop_front());
               nbits++;
               last_ev = cyc;
            end
            e_busy = in_frame && cyc > first_ev && cyc <= last_ev + GAP;
         end
         act = {busy, code_valid, frame_err, frame_cnt, code};
         exp = {e_busy, e_cv, e_fe, e_cnt, e_code};
         total++;
         if (act === exp) passed++;
         else $display("FAIL cycle %0d outputs {busy,cv,fe,cnt,code}: got %0h expected %0h", cyc, act, exp);
         if (code_valid) cv_tot++;
         if (frame_err)  fe_tot++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk50);
      #2;
   endtask

   task automatic pulse(input logic b, input int low);
      din = b; enclk = 1'b1;
      tick(4);
      enclk = 1'b0;
      tick(low);
   endtask

   task automatic send(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) pulse(v[i], 4);
   endtask

   task automatic idle();
      tick(GAP + 8);
   endtask

   int cv0, fe0;

   initial begin
      fork
         compare_loop();
      join_none
      tick(3);
      chk("reset_code", int'(code), 0);
      chk("reset_cnt", int'(frame_cnt), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;
      tick(3);

      cv0 = cv_tot; fe0 = fe_tot;
      send(32'hA5C, 12); idle();
      chk("a5c_code", int'(code), 'hA5C);
      chk("a5c_cnt", int'(frame_cnt), 1);
      chk("a5c_pulses", cv_tot - cv0, 1);

      cv0 = cv_tot;
      send(32'h3A5F, 14); idle();
      chk("long_code", int'(code), 'hE97);
      chk("long_pulses", cv_tot - cv0, 1);

      cv0 = cv_tot; fe0 = fe_tot;
      send(32'h15, 5); idle();
      chk("short_err", fe_tot - fe0, 1);
      chk("short_novalid", cv_tot - cv0, 0);
      chk("short_code_held", int'(code), 'hE97);

      cv0 = cv_tot; fe0 = fe_tot;
      for (int i = 0; i < 12; i++) pulse(1'(12'h5A3 >> i), (i == 5) ? 12 : 4);
      idle();
      chk("expiry_tie_code", int'(code), 'h5A3);
      chk("expiry_tie_valid", cv_tot - cv0, 1);
      chk("expiry_tie_noerr", fe_tot - fe0, 0);
      chk("expiry_tie_cnt", int'(frame_cnt), 3);

      cv0 = cv_tot; fe0 = fe_tot;
      pulse(1'b1, 4); pulse(1'b0, 4); pulse(1'b1, 13);
      send(32'h36C, 12); idle();
      chk("done_event_err", fe_tot - fe0, 1);
      chk("done_event_code", int'(code), 'h36C);
      chk("done_event_valid", cv_tot - cv0, 1);

      fe0 = fe_tot;
      send(32'h55, 7);
      rst = 1'b1; tick(2);
      chk("midrst_cnt", int'(frame_cnt), 0);
      rst = 1'b0; tick(2);
      cv0 = cv_tot;
      send(32'h123, 12); idle();
      chk("midrst_code", int'(code), 'h123);
      chk("midrst_cnt1", int'(frame_cnt), 1);
      chk("midrst_noerr", fe_tot - fe0, 0);
      chk("midrst_valid", cv_tot - cv0, 1);

      rst = 1'b1; tick(2); rst = 1'b0; tick(2);
      cv0 = cv_tot;
      for (int f = 0; f < 256; f++) begin
         send(32'((f * 37 + 5) & 12'hFFF), 12);
         idle();
         if (f == 254) chk("wrap_cnt255", int'(frame_cnt), 255);
      end
      chk("wrap_cnt0", int'(frame_cnt), 0);
      chk("wrap_pulses", cv_tot - cv0, 256);
      chk("wrap_last_code", int'(code), (255 * 37 + 5) & 'hFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
